seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Receive side of the 7-segment link. Samples the seven segment lines {a..g}, as
//  driven by the 3-bit to 7-seg display encoder, and waits for each pattern to settle.
//  Decodes every newly settled pattern back to its 3-bit value, or flags it as illegal.
//  Delivers results on a valid/ready stream so the multiplier test harness can
//  self-check what the display shows.
// PARAMETERS
//  SYNC_STAGES    2  flops in the input synchronizer (>=2)
//  STABLE_CYCLES  4  consecutive identical synced samples needed to accept a pattern (>=1)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  seg_a..seg_g in   1  segment lines, active high, asynchronous to clk
//  out_ready    in   1  sink ready
//  clr_overrun  in   1  one-cycle pulse, clears overrun
//  out_valid    out  1  decoded result available
//  out_value    out  3  decoded digit 0..7 (0 when out_err=1)
//  out_err      out  1  accepted pattern is not one of the 8 legal codes
//  overrun      out  1  sticky: a result was dropped because the sink stalled
// BEHAVIOUR
//  - Reset (async assert, sync deassert): synchronizer, candidate pattern (cand),
//    last accepted pattern (last_pat) and stability counter (cnt) all go to 0.
//    out_valid, out_value, out_err and overrun all reset to 0.
//  - pat = {a,b,c,d,e,f,g}, bit6 = a. The synchronizer output is sync_pat.
//  - FSM, two states:
//    WAIT:   sync_pat==cand. Idle. If sync_pat!=cand: cand<=sync_pat, cnt<=0, go to SETTLE.
//    SETTLE: if sync_pat!=cand: reload cand, cnt<=0, stay in SETTLE (glitch restarts count).
//            Else if cnt<STABLE_CYCLES-1: cnt++.
//            Else: accept the pattern and go to WAIT.
//  - On accept: if cand==last_pat, no event. If cand==7'b0000000 (blank), set last_pat<=cand
//    and issue no event; blank is neither emitted nor an error. Otherwise last_pat<=cand and
//    a result is produced.
//  - Decode table (pat -> value):
//      1111110->0  0110000->1  1101101->2  1111001->3
//      0110011->4  1011011->5  1011111->6  1110000->7
//    Any other non-blank pattern gives out_err=1 and out_value=0.
//  - Latency: with a clean edge, out_valid rises SYNC_STAGES+STABLE_CYCLES+1 rising edges
//    after the first edge that samples the new pattern. Defaults give 7.
//  - Handshake:
//    * out_value and out_err are stable while out_valid=1.
//    * A transfer occurs on a cycle with out_valid&&out_ready.
//    * out_valid falls the cycle after a transfer, unless a result is produced in that
//      same cycle; then the new data is loaded and out_valid stays 1 (back-to-back).
//  - Stall: a result produced while out_valid=1 and out_ready=0 is dropped.
//    The held result is kept, overrun<=1, and last_pat still updates.
//  - overrun is cleared by clr_overrun. If clear and set coincide, set wins.
//  - Reset mid-SETTLE or mid-handshake: the pending result is lost. The pattern present
//    after reset is re-emitted once it settles, because last_pat is blank.
// STRUCTURE
//  - Package seg7_pkg holds:
//    * localparam SEG_BLANK = 7'b0;
//    * SEG_CODE[0:7], the table above, shared with the encoder;
//    * function seg7_decode(pat) -> {err, value[2:0]}.
//  - Sub-module seg7_sync: SYNC_STAGES-deep 7-bit synchronizer with async reset.
//  - Top level contains the FSM, cnt ($clog2(STABLE_CYCLES)+1 bits), last_pat,
//    output register and overrun flag.
// TESTING
//  1. Reset, drive 1101101 held 20 cycles, out_ready=1 -> one beat out_value=2,
//     out_err=0, out_valid high exactly 7 edges after the first sampling edge.
//  2. Walk codes 0..7, each held 10 cycles, out_ready=1 -> 8 beats with values
//     0,1,..,7 in order; a code re-held after its beat produces no beat.
//  3. Drive 1111001 but toggle seg_g for 1 cycle every 3 cycles, then hold clean
//     -> no beat during toggling; a single beat value=3 after clean hold + latency.
//  4. Drive 0000001 (illegal), then blank, then 0000001 -> two beats, out_err=1,
//     out_value=0; blank produces nothing.
//  5. out_ready=0, drive 4 then 5 (each settled) -> held beat value=4 and overrun=1.
//     Raise out_ready -> value 4 transfers, no value 5. Then clr_overrun -> overrun=0.
//  6. Assert rst_n=0 mid-SETTLE while 6 is on the lines -> all outputs 0 immediately.
//     After release, a beat value=6 arrives 7 edges later.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment code table, decode helper and FSM state type
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0;

  // Segment order {a,b,c,d,e,f,g}; index is the 3-bit value shown.
  localparam logic [6:0] SEG_CODE [0:7] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000
  };

  typedef enum logic {
    ST_WAIT,
    ST_SETTLE
  } seg7_state_e;

  // Returns {err, value}; unknown patterns give err=1, value=0.
  function automatic logic [3:0] seg7_decode(input logic [6:0] pat);
    logic [3:0] res;
    res = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      if (pat == SEG_CODE[i]) res = {1'b0, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_sync.sv
// rtl/seg7_sync.sv - multi-stage synchronizer for the asynchronous segment lines
module seg7_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[SYNC_STAGES-1];

endmodule

// File: rtl/seg7_capture_decoder.sv
// rtl/seg7_capture_decoder.sv - settles, decodes and streams patterns seen on the 7-seg link
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic       out_valid,
  output logic [2:0] out_value,
  output logic       out_err,
  output logic       overrun
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0]    raw_pat;
  logic [6:0]    sync_pat;
  logic [6:0]    cand;
  logic [6:0]    last_pat;
  logic [CW-1:0] cnt;
  seg7_state_e   state;
  logic          res_pend;
  logic [3:0]    res_dec;

  assign raw_pat = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  seg7_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (7)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (raw_pat),
    .dout  (sync_pat)
  );

  // Settling FSM; an accepted pattern becomes a one-cycle result pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT;
      cand     <= '0;
      cnt      <= '0;
      last_pat <= '0;
      res_pend <= 1'b0;
      res_dec  <= '0;
    end else begin
      res_pend <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (sync_pat != cand) begin
            cand  <= sync_pat;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (sync_pat != cand) begin
            cand <= sync_pat;
            cnt  <= '0;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            state <= ST_WAIT;
            if (cand != last_pat) begin
              last_pat <= cand;
              if (cand != SEG_BLANK) begin
                res_pend <= 1'b1;
                res_dec  <= seg7_decode(cand);
              end
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // Output holding register; a result arriving while the sink stalls is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (res_pend) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_err   <= res_dec[3];
          out_value <= res_dec[2:0];
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (res_pend && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb/tb_seg7_capture_decoder.sv - directed and randomized checks of seg7_capture_decoder
module tb_seg7_capture_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] pat;
  logic       out_ready;
  logic       clr_overrun;
  logic       out_valid;
  logic [2:0] out_value;
  logic       out_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  logic [3:0] got_q [$];
  logic [3:0] exp_q [$];
  logic [6:0] model_last;

  logic [6:0] codes [8];

  always #5 clk = ~clk;

  seg7_capture_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_a       (pat[6]),
    .seg_b       (pat[5]),
    .seg_c       (pat[4]),
    .seg_d       (pat[3]),
    .seg_e       (pat[2]),
    .seg_f       (pat[1]),
    .seg_g       (pat[0]),
    .out_ready   (out_ready),
    .clr_overrun (clr_overrun),
    .out_valid   (out_valid),
    .out_value   (out_value),
    .out_err     (out_err),
    .overrun     (overrun)
  );

  // A beat is recorded when valid and ready are both high going into a rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_err, out_value});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 8; i++) if (codes[i] == p) return {1'b0, 3'(i)};
    return 4'b1000;
  endfunction

  // A settled pattern yields a beat only if new and non-blank; drop models a stalled sink.
  task automatic model_accept(input logic [6:0] p, input bit drop);
    if (p != model_last) begin
      model_last = p;
      if (p != 7'b0 && !drop) exp_q.push_back(ref_decode(p));
    end
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_beat"}, {28'd0, got_q[i]}, {28'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    lat = 0;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check(tag, lat, 7);
  endtask

  initial begin
    logic [6:0] prev;
    logic [6:0] p;
    int len;

    codes[0] = 7'b1111110; codes[1] = 7'b0110000; codes[2] = 7'b1101101; codes[3] = 7'b1111001;
    codes[4] = 7'b0110011; codes[5] = 7'b1011011; codes[6] = 7'b1011111; codes[7] = 7'b1110000;
    model_last  = 7'b0;
    rst_n       = 1'b0;
    pat         = 7'b0;
    out_ready   = 1'b1;
    clr_overrun = 1'b0;

    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_value", out_value, 0);
    check("rst_err", out_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(5);

    // Single clean pattern with latency measurement
    pat = codes[2];
    measure_latency("t1_latency");
    check("t1_value", out_value, 2);
    check("t1_err", out_err, 0);
    model_accept(codes[2], 0);
    tick(12);
    compare_beats("t1");

    // Walk all codes, then a short glitch that returns to the held code
    for (int i = 0; i < 8; i++) begin
      pat = codes[i];
      tick(10);
      model_accept(codes[i], 0);
    end
    pat = codes[5];
    tick(2);
    pat = codes[7];
    tick(12);
    compare_beats("t2");

    // Toggling seg_g keeps restarting the settle count
    for (int k = 0; k < 6; k++) begin
      pat = codes[3];
      tick(2);
      pat = codes[3] ^ 7'b0000001;
      tick(1);
    end
    check("t3_no_beat", got_q.size(), 0);
    pat = codes[3];
    tick(12);
    model_accept(codes[3], 0);
    compare_beats("t3");

    // Illegal pattern, blank, illegal again
    pat = 7'b0000001; tick(10); model_accept(7'b0000001, 0);
    pat = 7'b0000000; tick(10); model_accept(7'b0000000, 0);
    pat = 7'b0000001; tick(10); model_accept(7'b0000001, 0);
    tick(4);
    compare_beats("t4");

    // Stalled sink: second result dropped, overrun sticky until cleared
    out_ready = 1'b0;
    pat = codes[4]; tick(12); model_accept(codes[4], 0);
    check("t5_held_valid", out_valid, 1);
    check("t5_held_value", out_value, 4);
    pat = codes[5]; tick(12); model_accept(codes[5], 1);
    check("t5_kept_value", out_value, 4);
    check("t5_overrun_set", overrun, 1);
    check("t5_no_xfer", got_q.size(), 0);
    out_ready = 1'b1;
    tick(10);
    compare_beats("t5");
    check("t5_valid_low", out_valid, 0);
    check("t5_overrun_sticky", overrun, 1);
    clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
    check("t5_overrun_clr", overrun, 0);

    // Reset while settling and with a held beat pending
    out_ready = 1'b0;
    pat = codes[2]; tick(12);
    check("t6_pre_valid", out_valid, 1);
    pat = codes[6]; tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_value", out_value, 0);
    check("t6_rst_err", out_err, 0);
    check("t6_rst_overrun", overrun, 0);
    model_last = 7'b0;
    out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    measure_latency("t6_latency");
    check("t6_value", out_value, 6);
    model_accept(codes[6], 0);
    tick(12);
    compare_beats("t6");

    // Random holds: long ones settle, short ones never do
    prev = pat;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(3))
        0, 1:    p = codes[$urandom_range(7)];
        2:       p = 7'($urandom);
        default: p = 7'b0;
      endcase
      if (p == prev) p = p ^ 7'b0100000;
      len = ($urandom_range(2) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 14);
      pat = p;
      tick(len);
      if (len >= 10) model_accept(p, 0);
      prev = p;
    end
    tick(14);
    model_accept(prev, 0);
    compare_beats("rand");
    check("rand_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
